// File: rtl/ttl_pulse_count_checker_if.sv
// Window-count checker bus: counting-stage inputs, clear, and checker results.
// The master drives the window reference, count and clear; the slave reports.
interface ttl_pulse_count_checker_if;
   logic        clk_1Mz;
   logic [7:0]  cnt_form_res_ttl;
   logic        clr_stat;
   logic        sample_vld;
   logic [7:0]  last_cnt;
   logic        win_ok;
   logic [15:0] win_total;
   logic [15:0] err_total;
   logic        fault;

   modport master (
      output clk_1Mz, cnt_form_res_ttl, clr_stat,
      input  sample_vld, last_cnt, win_ok, win_total, err_total, fault
   );

   modport slave (
      input  clk_1Mz, cnt_form_res_ttl, clr_stat,
      output sample_vld, last_cnt, win_ok, win_total, err_total, fault
   );
endinterface

// File: rtl/ttl_pulse_count_checker.sv
// Per-window TTL pulse count checker with tolerance compare,
// saturating window/error statistics and a latched run-length fault.
module ttl_pulse_count_checker #(
   parameter logic [7:0]  EXP_CNT  = 8'd50,
   parameter logic [7:0]  TOL      = 8'd2,
   parameter int          FAIL_RUN = 4,
   parameter int          SKIP_WIN = 2,
   parameter logic [15:0] SAT_MAX  = 16'hFFFF
) (
   input logic                      clk_100Mz,
   input logic                      rst,
   ttl_pulse_count_checker_if.slave bus
);
   localparam logic [1:0] S_SKIP  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_FAULT = 2'd2;
   localparam logic [3:0] LP_RUN  = 4'(FAIL_RUN);
   localparam logic [1:0] LP_SKIP = 2'(SKIP_WIN);
   localparam logic [1:0] S_INIT  = (SKIP_WIN == 0) ? S_RUN : S_SKIP;

   logic        r_prev;
   logic        r_smp;
   logic        r_vld;
   logic        r_ok;
   logic        r_fault;
   logic [7:0]  r_last;
   logic [15:0] r_win;
   logic [15:0] r_err;
   logic [3:0]  r_bad;
   logic [1:0]  r_skip;
   logic [1:0]  r_state;

   logic        w_bnd;
   logic        w_pass;
   logic [8:0]  w_cnt;
   logic [8:0]  w_exp;
   logic [8:0]  w_diff;
   logic [3:0]  w_bad_nx;

   // Counting stage registers on the boundary, so sample one cycle later.
   assign w_bnd    = bus.clk_1Mz & ~r_prev;
   assign w_cnt    = {1'b0, bus.cnt_form_res_ttl};
   assign w_exp    = {1'b0, EXP_CNT};
   assign w_diff   = (w_cnt >= w_exp) ? (w_cnt - w_exp) : (w_exp - w_cnt);
   assign w_pass   = (w_diff <= {1'b0, TOL});
   assign w_bad_nx = (r_bad >= LP_RUN) ? r_bad : (r_bad + 4'd1);

   always_ff @(posedge clk_100Mz) begin
      if (rst) begin
         r_prev  <= 1'b0;
         r_smp   <= 1'b0;
         r_vld   <= 1'b0;
         r_ok    <= 1'b0;
         r_fault <= 1'b0;
         r_last  <= 8'd0;
         r_win   <= 16'd0;
         r_err   <= 16'd0;
         r_bad   <= 4'd0;
         r_skip  <= LP_SKIP;
         r_state <= S_INIT;
      end else begin
         r_prev <= bus.clk_1Mz;
         r_smp  <= w_bnd;
         r_vld  <= 1'b0;
         if (bus.clr_stat) begin
            r_ok    <= 1'b0;
            r_fault <= 1'b0;
            r_win   <= 16'd0;
            r_err   <= 16'd0;
            r_bad   <= 4'd0;
            r_skip  <= LP_SKIP;
            r_state <= S_INIT;
         end else if (r_smp) begin
            case (r_state)
               S_SKIP: begin
                  if (r_skip != 2'd0)
                     r_skip <= r_skip - 2'd1;
                  if (r_skip <= 2'd1)
                     r_state <= S_RUN;
               end
               default: begin
                  r_vld  <= 1'b1;
                  r_last <= bus.cnt_form_res_ttl;
                  r_ok   <= w_pass;
                  if (r_win != SAT_MAX)
                     r_win <= r_win + 16'd1;
                  if (w_pass) begin
                     r_bad <= 4'd0;
                  end else begin
                     if (r_err != SAT_MAX)
                        r_err <= r_err + 16'd1;
                     r_bad <= w_bad_nx;
                     if (w_bad_nx == LP_RUN) begin
                        r_fault <= 1'b1;
                        r_state <= S_FAULT;
                     end
                  end
               end
            endcase
         end
      end
   end

   assign bus.sample_vld = r_vld;
   assign bus.last_cnt   = r_last;
   assign bus.win_ok     = r_ok;
   assign bus.win_total  = r_win;
   assign bus.err_total  = r_err;
   assign bus.fault      = r_fault;
endmodule

// File: tb/tb_ttl_pulse_count_checker.sv
// Randomized self-checking bench for ttl_pulse_count_checker against a
// window-level reference model (counter ceiling shortened to 40).
module tb_ttl_pulse_count_checker;
   localparam logic [7:0] EXP  = 8'd50;
   localparam logic [7:0] TOL  = 8'd2;
   localparam int         FRUN = 4;
   localparam int         SKIP = 2;
   localparam int         SAT  = 40;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ttl_pulse_count_checker_if bus();

   ttl_pulse_count_checker #(
      .EXP_CNT(EXP), .TOL(TOL), .FAIL_RUN(FRUN),
      .SKIP_WIN(SKIP), .SAT_MAX(16'(SAT))
   ) dut (
      .clk_100Mz(clk),
      .rst(rst),
      .bus(bus)
   );

   int total = 0;
   int bad   = 0;

   // reference model state, one step per window
   int         m_skip, m_run, m_wt, m_et;
   bit         m_ok, m_fault;
   logic [7:0] m_last;

   // observations captured two cycles after each window's rising edge
   logic        o_vld, o_ok, o_fault;
   logic [7:0]  o_last;
   logic [15:0] o_wt, o_et;
   int          o_stray;
   bit          e_vld;

   function automatic void model_clear();
      m_skip = SKIP; m_run = 0; m_wt = 0; m_et = 0;
      m_ok = 0; m_fault = 0;
   endfunction

   function automatic void model_reset();
      model_clear();
      m_last = 8'd0;
   endfunction

   function automatic bit model_sample(input logic [7:0] c);
      int d;
      if (m_skip > 0) begin
         m_skip--;
         return 1'b0;
      end
      d = (int'(c) > int'(EXP)) ? int'(c) - int'(EXP) : int'(EXP) - int'(c);
      m_last = c;
      m_ok = (d <= int'(TOL));
      if (m_wt < SAT) m_wt++;
      if (m_ok) m_run = 0;
      else begin
         if (m_et < SAT) m_et++;
         m_run++;
      end
      if (m_run >= FRUN) m_fault = 1;
      return 1'b1;
   endfunction

   task automatic run_window(input logic [7:0] c, input int hi,
                             input int lo, input bit clr_smp);
      @(negedge clk);
      bus.clk_1Mz = 1'b1;
      bus.cnt_form_res_ttl = c;
      o_stray = 0;
      for (int i = 1; i <= hi + lo; i++) begin
         @(negedge clk);
         if (i == 2) begin
            o_vld = bus.sample_vld; o_last = bus.last_cnt;
            o_ok = bus.win_ok; o_fault = bus.fault;
            o_wt = bus.win_total; o_et = bus.err_total;
            if (clr_smp) begin
               e_vld = 1'b0;
               model_clear();
            end else begin
               e_vld = model_sample(c);
            end
         end else if (bus.sample_vld) begin
            o_stray++;
         end
         if (i == 1) bus.clr_stat = clr_smp;
         if (i == 2) bus.clr_stat = 1'b0;
         if (i == hi) bus.clk_1Mz = 1'b0;
      end
   endtask

   task automatic pulse_clear();
      @(negedge clk);
      bus.clr_stat = 1'b1;
      @(negedge clk);
      bus.clr_stat = 1'b0;
      model_clear();
   endtask

   task automatic test_reset();
      bus.clk_1Mz = 1'b0;
      bus.clr_stat = 1'b0;
      bus.cnt_form_res_ttl = EXP;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      total++;
      if ({bus.sample_vld, bus.last_cnt, bus.win_ok, bus.win_total,
           bus.err_total, bus.fault} !== '0) begin
         bad++;
         $display("FAIL reset_outs: got vld=%b last=%0d ok=%b wt=%0d et=%0d flt=%b want all 0",
                  bus.sample_vld, bus.last_cnt, bus.win_ok, bus.win_total,
                  bus.err_total, bus.fault);
      end
      rst = 1'b0;
      model_reset();
      for (int w = 0; w < 3; w++) begin
         run_window(EXP, 50, 50, 1'b0);
         total++;
         if (o_vld !== (w == 2) || o_stray != 0) begin
            bad++;
            $display("FAIL skip_vld: win %0d got vld=%b stray=%0d want vld=%b stray=0",
                     w, o_vld, o_stray, (w == 2));
         end
      end
      total++;
      if (o_last !== 8'd50 || o_ok !== 1'b1 || o_wt !== 16'd1) begin
         bad++;
         $display("FAIL first_sample: got last=%0d ok=%b wt=%0d want 50 1 1",
                  o_last, o_ok, o_wt);
      end
   endtask

   task automatic test_tolerance();
      logic [7:0] cs [5];
      bit         ok [5];
      cs = '{8'd48, 8'd52, 8'd47, 8'd53, 8'd0};
      ok = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      for (int k = 0; k < 5; k++) begin
         run_window(cs[k], $urandom_range(2, 6), $urandom_range(2, 6), 1'b0);
         total++;
         if (o_vld !== 1'b1 || o_ok !== ok[k] || o_last !== cs[k] || o_fault !== 1'b0) begin
            bad++;
            $display("FAIL tol_%0d: got vld=%b ok=%b last=%0d flt=%b want 1 %b %0d 0",
                     k, o_vld, o_ok, o_last, o_fault, ok[k], cs[k]);
         end
      end
      total++;
      if (o_et !== 16'd3 || o_wt !== 16'd6) begin
         bad++;
         $display("FAIL tol_totals: got et=%0d wt=%0d want 3 6", o_et, o_wt);
      end
   endtask

   task automatic test_fault_run();
      logic [7:0] cs [8];
      cs = '{8'd10, 8'd10, 8'd10, 8'd50, 8'd10, 8'd10, 8'd10, 8'd10};
      pulse_clear();
      for (int k = 0; k < 2; k++) begin
         run_window(EXP, 3, 3, 1'b0);
         total++;
         if (o_vld !== 1'b0) begin
            bad++;
            $display("FAIL clr_skip_%0d: got vld=%b want 0", k, o_vld);
         end
      end
      for (int k = 0; k < 8; k++) begin
         run_window(cs[k], $urandom_range(2, 5), $urandom_range(2, 5), 1'b0);
         total++;
         if (o_vld !== 1'b1 || o_fault !== (k == 7)) begin
            bad++;
            $display("FAIL fault_%0d: got vld=%b flt=%b want 1 %b",
                     k, o_vld, o_fault, (k == 7));
         end
      end
      total++;
      if (o_et !== 16'd7 || o_wt !== 16'd8) begin
         bad++;
         $display("FAIL fault_totals: got et=%0d wt=%0d want 7 8", o_et, o_wt);
      end
   endtask

   task automatic test_clear_collision();
      run_window(8'd10, 3, 3, 1'b1);
      total++;
      if (o_vld !== 1'b0 || o_fault !== 1'b0 || o_wt !== 16'd0 ||
          o_et !== 16'd0 || o_ok !== 1'b0 || o_last !== 8'd10) begin
         bad++;
         $display("FAIL clr_collide: got vld=%b flt=%b wt=%0d et=%0d ok=%b last=%0d want 0 0 0 0 0 10",
                  o_vld, o_fault, o_wt, o_et, o_ok, o_last);
      end
      for (int k = 0; k < 3; k++) begin
         run_window(EXP, 2, 2, 1'b0);
         total++;
         if (o_vld !== (k == 2) || o_stray != 0) begin
            bad++;
            $display("FAIL clr_reskip_%0d: got vld=%b stray=%0d want %b 0",
                     k, o_vld, o_stray, (k == 2));
         end
      end
   endtask

   task automatic test_random();
      logic [7:0] c;
      bit         clr;
      for (int k = 0; k < 40; k++) begin
         c = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(0, 255))
                                         : 8'($urandom_range(44, 56));
         clr = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 19) == 0) pulse_clear();
         run_window(c, $urandom_range(2, 8), $urandom_range(2, 8), clr);
         total++;
         if (o_vld !== e_vld || o_stray != 0 || o_last !== m_last ||
             o_ok !== m_ok || o_wt !== 16'(m_wt) || o_et !== 16'(m_et) ||
             o_fault !== m_fault) begin
            bad++;
            $display("FAIL rand_%0d: got vld=%b last=%0d ok=%b wt=%0d et=%0d flt=%b want %b %0d %b %0d %0d %b",
                     k, o_vld, o_last, o_ok, o_wt, o_et, o_fault,
                     e_vld, m_last, m_ok, m_wt, m_et, m_fault);
         end
      end
   endtask

   task automatic test_saturation();
      pulse_clear();
      repeat (2) run_window(EXP, 2, 2, 1'b0);
      for (int k = 0; k < SAT + 3; k++) begin
         run_window(8'd10, 2, 2, 1'b0);
         if (k >= SAT - 1) begin
            total++;
            if (o_wt !== 16'(SAT) || o_et !== 16'(SAT) || o_fault !== 1'b1) begin
               bad++;
               $display("FAIL sat_%0d: got wt=%0d et=%0d flt=%b want %0d %0d 1",
                        k, o_wt, o_et, o_fault, SAT, SAT);
            end
         end
      end
   endtask

   task automatic test_reset_fault();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      total++;
      if ({bus.sample_vld, bus.last_cnt, bus.win_ok, bus.win_total,
           bus.err_total, bus.fault} !== '0) begin
         bad++;
         $display("FAIL rst_fault: got vld=%b last=%0d ok=%b wt=%0d et=%0d flt=%b want all 0",
                  bus.sample_vld, bus.last_cnt, bus.win_ok, bus.win_total,
                  bus.err_total, bus.fault);
      end
      rst = 1'b0;
      model_reset();
      for (int k = 0; k < 3; k++) begin
         run_window(8'd51, 3, 2, 1'b0);
         total++;
         if (o_vld !== (k == 2) || o_wt !== 16'(k == 2)) begin
            bad++;
            $display("FAIL rst_reskip_%0d: got vld=%b wt=%0d want %b %0d",
                     k, o_vld, o_wt, (k == 2), (k == 2));
         end
      end
   endtask

   initial begin
      test_reset();
      test_tolerance();
      test_fault_run();
      test_clear_collision();
      test_random();
      test_saturation();
      test_reset_fault();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/ttl_pulse_count_checker.md
# ttl_pulse_count_checker

Downstream consumer of the per-window TTL pulse count produced by the res_ttl pulse-counting stage. Once per 1 MHz window it samples the 8-bit count, checks it against an expected value with tolerance, and keeps saturating window and error statistics. After a configurable run of consecutive bad windows it latches a fault flag. Runs entirely in the clk_100Mz domain, with clk_1Mz sampled as a data-rate reference.

## Interface
- EXP_CNT, default 8'd50: expected pulses per window.
- TOL, default 8'd2: allowed deviation. A window passes when |cnt − EXP_CNT| ≤ TOL.
- FAIL_RUN, default 4: consecutive failing windows that set fault. Legal range 1..15.
- SKIP_WIN, default 2: windows discarded after reset or clear. Legal range 0..3.

Ports:
- clk_100Mz  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- clk_1Mz  in  1  window reference, same signal that feeds the counting stage.
- cnt_form_res_ttl  in  8  per-window pulse count from the counting stage.
- clr_stat  in  1  synchronous clear of statistics and fault. Parameters are unaffected.
- sample_vld  out  1  one-cycle pulse when a window result is checked.
- last_cnt  out  8  most recently checked count.
- win_ok  out  1  pass/fail of the last checked window.
- win_total  out  16  checked windows, saturating at 16'hFFFF.
- err_total  out  16  failing windows, saturating at 16'hFFFF.
- fault  out  1  latched fault flag.

## Operation
- Edge detect: a register holds the previous clk_1Mz. A window boundary is the cycle where {prev, clk_1Mz} == 2'b01.
- The counting stage registers its count on that same cycle. This block therefore samples cnt_form_res_ttl on the cycle after the boundary (the sample cycle).
- Compare on 9-bit values: diff = cnt − EXP_CNT if cnt ≥ EXP_CNT, else EXP_CNT − cnt. Pass when diff ≤ TOL. No wrap-around is permitted, so cnt = 0 with EXP_CNT = 255 gives diff = 255.
- FSM states:
  - SKIP: discard SKIP_WIN sample cycles. Each sample cycle decrements skip_cnt; at 0 go to RUN. With SKIP_WIN = 0, enter RUN directly from reset.
  - RUN: every sample cycle does all of the following:
    - assert sample_vld;
    - update last_cnt and win_ok;
    - increment win_total;
    - on fail, increment err_total and bad_run; on pass, clear bad_run;
    - when bad_run reaches FAIL_RUN, set fault and go to FAULT.
  - FAULT: statistics keep updating exactly as in RUN. fault stays 1; bad_run saturates at FAIL_RUN. Leave only on rst or clr_stat.
- clr_stat (any state) zeroes win_total, err_total, bad_run, fault and win_ok, reloads skip_cnt and goes to SKIP. If clr_stat coincides with a sample cycle, clr_stat wins and that sample is discarded. last_cnt is kept.
- Discarded samples (SKIP, or clr_stat) produce no sample_vld.
- Saturated counters hold at FFFF. They never wrap.

## Timing
- Reset values: all outputs 0, the prev register 0, state SKIP, skip_cnt = SKIP_WIN.
- rst mid-window: the window in progress is treated like any other. The first boundary after rst still counts toward SKIP.
- Latency from clk_1Mz rising (as seen at the input) to the updated sample outputs:
  - cycle 0: boundary detected;
  - cycle 1: sample;
  - cycle 2: registered outputs valid, with sample_vld high for exactly this one cycle.
- fault rises in the same cycle as the sample_vld of the FAIL_RUN-th consecutive failing window.
- clk_1Mz high and low phases are each ≥ 2 clk_100Mz cycles. Glitches shorter than that are out of scope.

## Test plan
- Reset/skip:
  - Stimulus: rst for 3 cycles, then clk_1Mz at 1 MHz (50/50) with cnt held at 50.
  - Required: all outputs 0 after reset; no sample_vld for the first 2 boundaries; the 3rd boundary gives sample_vld 2 cycles after the clk_1Mz edge with last_cnt = 50, win_ok = 1, win_total = 1.
- Tolerance edges:
  - Stimulus: cnt = 48, then 52, 47, 53, 0.
  - Required: win_ok = 1, 1, 0, 0, 0; err_total ends at 3; fault stays 0 at the default FAIL_RUN of 4.
- Fault run:
  - Stimulus: 3 bad windows, 1 good, then 4 bad (cnt = 10).
  - Required: fault stays 0 through the first 3 bad windows and the good one. fault = 1 coincides with the 8th sample_vld. err_total = 7, win_total = 8.
- Clear collision:
  - Stimulus: assert clr_stat on a sample cycle while in FAULT.
  - Required: next cycle fault = 0, win_total = 0, err_total = 0, no sample_vld, state SKIP; the next 2 windows are discarded.
- Saturation:
  - Stimulus: force win_total and err_total to FFFE (or run a shortened bench parameter), then 3 bad windows.
  - Required: both counters read FFFF and hold; fault still asserts.
- Reset mid-FAULT:
  - Stimulus: assert rst while in FAULT, between boundaries.
  - Required: next cycle all outputs are 0 and the state is SKIP.
